// File: rtl/joy_db15_cond.sv
// DB15 joystick conditioner: input sync, per-button debounce, SOCD cleaning,
// press pulses and a Start+Select hold combo that raises menu_pulse.
module joy_db15_cond #(
   parameter int unsigned TICK_DIV     = 4800,
   parameter int unsigned DB_SAMPLES   = 4,
   parameter int unsigned SOCD_NEUTRAL = 1,
   parameter int unsigned COMBO_TICKS  = 10000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] joystick1_in,
   input  logic [15:0] joystick2_in,
   output logic [15:0] joy1_out,
   output logic [15:0] joy2_out,
   output logic [15:0] joy1_press,
   output logic [15:0] joy2_press,
   output logic        menu_pulse,
   output logic        sample_tick
);

   localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned CW = $clog2(DB_SAMPLES + 1);
   localparam int unsigned HW = $clog2(COMBO_TICKS + 1);

   typedef enum logic [1:0] {StIdle, StHold, StFired} state_e;

   // Both players packed as {p2[11:0], p1[11:0]}; bits 15:12 are not wired.
   logic [23:0]   sync1_q, sync2_q;
   logic [23:0]   stable_q;
   logic [CW-1:0] db_cnt_q [24];
   logic [23:0]   clean;
   logic [23:0]   out_q, press_q;
   logic [TW-1:0] tick_cnt_q;
   logic [HW-1:0] hold_q, hold_d;
   state_e        state_q, state_d;
   logic          combo;
   logic          unused_hi;

   assign unused_hi = ^{joystick1_in[15:12], joystick2_in[15:12]};

   function automatic logic [11:0] socd(input logic [11:0] s);
      logic [11:0] r;
      r = s;
      if (SOCD_NEUTRAL != 0) begin
         if (s[0] & s[1]) r[1:0] = 2'b00;
         if (s[2] & s[3]) r[3:2] = 2'b00;
      end
      return r;
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= {joystick2_in[11:0], joystick1_in[11:0]};
         sync2_q <= sync1_q;
      end
   end

   assign sample_tick = (tick_cnt_q == TW'(TICK_DIV - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tick_cnt_q <= '0;
      end else if (sample_tick) begin
         tick_cnt_q <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_q + TW'(1);
      end
   end

   // A new level is accepted only after DB_SAMPLES consecutive ticks disagree.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable_q <= '0;
         for (int i = 0; i < 24; i++) db_cnt_q[i] <= '0;
      end else if (sample_tick) begin
         for (int i = 0; i < 24; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
               db_cnt_q[i] <= '0;
            end else if (db_cnt_q[i] == CW'(DB_SAMPLES - 1)) begin
               stable_q[i] <= sync2_q[i];
               db_cnt_q[i] <= '0;
            end else begin
               db_cnt_q[i] <= db_cnt_q[i] + CW'(1);
            end
         end
      end
   end

   assign clean = {socd(stable_q[23:12]), socd(stable_q[11:0])};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_q   <= '0;
         press_q <= '0;
      end else begin
         out_q   <= clean;
         press_q <= clean & ~out_q;
      end
   end

   assign joy1_out   = {4'h0, out_q[11:0]};
   assign joy2_out   = {4'h0, out_q[23:12]};
   assign joy1_press = {4'h0, press_q[11:0]};
   assign joy2_press = {4'h0, press_q[23:12]};

   assign combo = (out_q[10] & out_q[11]) | (out_q[22] & out_q[23]);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   end

   // A release in the final tick's cycle takes priority over firing.
   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      menu_pulse = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (combo) begin
               state_d = StHold;
               hold_d  = '0;
            end
         end
         StHold: begin
            if (!combo) begin
               state_d = StIdle;
            end else if (sample_tick) begin
               if (hold_q == HW'(COMBO_TICKS - 1)) begin
                  state_d    = StFired;
                  menu_pulse = 1'b1;
               end else begin
                  hold_d = hold_q + HW'(1);
               end
            end
         end
         StFired: begin
            if (!combo) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

endmodule

// File: tb/tb_joy_db15_cond.sv
// Bench for joy_db15_cond: cycle model check of every output, plus a vector
// table and directed sequences for debounce, SOCD, combo and reset corners.
module tb_joy_db15_cond;

   localparam int unsigned TD = 4;
   localparam int unsigned DS = 3;
   localparam int unsigned CT = 5;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] joystick1_in = 16'h0FFF;
   logic [15:0] joystick2_in = 16'h0FFF;
   logic [15:0] joy1_out, joy2_out, joy1_press, joy2_press;
   logic        menu_pulse, sample_tick;
   logic [15:0] b_joy1_out, b_joy2_out, b_joy1_press, b_joy2_press;
   logic        b_menu_pulse, b_sample_tick;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   joy_db15_cond #(
      .TICK_DIV(TD), .DB_SAMPLES(DS), .SOCD_NEUTRAL(1), .COMBO_TICKS(CT)
   ) u_dut (
      .clk(clk), .reset_n(reset_n),
      .joystick1_in(joystick1_in), .joystick2_in(joystick2_in),
      .joy1_out(joy1_out), .joy2_out(joy2_out),
      .joy1_press(joy1_press), .joy2_press(joy2_press),
      .menu_pulse(menu_pulse), .sample_tick(sample_tick)
   );

   joy_db15_cond #(
      .TICK_DIV(TD), .DB_SAMPLES(DS), .SOCD_NEUTRAL(0), .COMBO_TICKS(CT)
   ) u_dut_pass (
      .clk(clk), .reset_n(reset_n),
      .joystick1_in(joystick1_in), .joystick2_in(joystick2_in),
      .joy1_out(b_joy1_out), .joy2_out(b_joy2_out),
      .joy1_press(b_joy1_press), .joy2_press(b_joy2_press),
      .menu_pulse(b_menu_pulse), .sample_tick(b_sample_tick)
   );

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference ----------------
   function automatic logic [11:0] clean(input logic [11:0] s, input bit neutral);
      logic [11:0] r;
      r = s;
      if (neutral && s[0] && s[1]) r = r & ~12'h003;
      if (neutral && s[2] && s[3]) r = r & ~12'h00C;
      return r;
   endfunction

   function automatic bit combo_of(input logic [23:0] o);
      return (o[10] && o[11]) || (o[22] && o[23]);
   endfunction

   logic [23:0] m_s1, m_s2, m_stable, m_out, m_press, m_outp, m_pressp, m_cl;
   int          m_cnt [24];
   int          m_tc, m_hold;
   bit          m_armed, m_fired, m_tk, m_c;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_s1 = '0; m_s2 = '0; m_stable = '0;
         m_out = '0; m_press = '0; m_outp = '0; m_pressp = '0;
         m_tc = 0; m_hold = 0; m_armed = 0; m_fired = 0;
         for (int i = 0; i < 24; i++) m_cnt[i] = 0;
      end else begin
         m_tk = (m_tc == TD - 1);
         m_c  = combo_of(m_out);
         if (!m_c) begin
            m_armed = 0;
            m_fired = 0;
         end else if (!m_armed && !m_fired) begin
            m_armed = 1;
            m_hold  = 0;
         end else if (m_armed && m_tk) begin
            if (m_hold == CT - 1) begin
               m_armed = 0;
               m_fired = 1;
            end else begin
               m_hold++;
            end
         end
         m_cl    = {clean(m_stable[23:12], 1), clean(m_stable[11:0], 1)};
         m_press = m_cl & ~m_out;
         m_out   = m_cl;
         m_cl    = {clean(m_stable[23:12], 0), clean(m_stable[11:0], 0)};
         m_pressp = m_cl & ~m_outp;
         m_outp   = m_cl;
         if (m_tk) begin
            for (int i = 0; i < 24; i++) begin
               if (m_s2[i] == m_stable[i]) begin
                  m_cnt[i] = 0;
               end else begin
                  m_cnt[i]++;
                  if (m_cnt[i] == DS) begin
                     m_stable[i] = m_s2[i];
                     m_cnt[i] = 0;
                  end
               end
            end
         end
         m_s2 = m_s1;
         m_s1 = {joystick2_in[11:0], joystick1_in[11:0]};
         m_tc = (m_tc + 1) % TD;
      end
   end

   // Event counters for the directed sequences.
   int menu_cnt = 0, p2b0_cnt = 0, out4_cnt = 0, press1_cnt = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         bit exp_menu;
         exp_menu = combo_of(m_out) && m_armed && (m_tc == TD - 1) && (m_hold == CT - 1);
         chk("joy1_out", joy1_out, {4'h0, m_out[11:0]});
         chk("joy2_out", joy2_out, {4'h0, m_out[23:12]});
         chk("joy1_press", joy1_press, {4'h0, m_press[11:0]});
         chk("joy2_press", joy2_press, {4'h0, m_press[23:12]});
         chk("menu_pulse", {15'h0, menu_pulse}, {15'h0, exp_menu});
         chk("sample_tick", {15'h0, sample_tick}, {15'h0, m_tc == TD - 1});
         chk("pass_joy1_out", b_joy1_out, {4'h0, m_outp[11:0]});
         chk("pass_joy2_out", b_joy2_out, {4'h0, m_outp[23:12]});
         chk("pass_joy1_press", b_joy1_press, {4'h0, m_pressp[11:0]});
         chk("pass_joy2_press", b_joy2_press, {4'h0, m_pressp[23:12]});
         chk("pass_menu_pulse", {15'h0, b_menu_pulse}, {15'h0, exp_menu});
         chk("pass_sample_tick", {15'h0, b_sample_tick}, {15'h0, m_tc == TD - 1});
      end
      menu_cnt   += int'(menu_pulse);
      p2b0_cnt   += int'(joy2_press[0]);
      out4_cnt   += int'(joy1_out[4]);
      press1_cnt += int'(joy1_press != 16'h0);
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_clk(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   // Advance to the next cycle in which sample_tick is high.
   task automatic wait_tick(input int n);
      repeat (n) begin
         int k;
         k = 0;
         do begin
            wait_clk(1);
            k++;
         end while (!sample_tick && k < 2 * TD);
         if (!sample_tick) chk("tick_timeout", {15'h0, sample_tick}, 16'h1);
      end
   endtask

   task automatic chk_all_zero(input string name);
      chk(name, joy1_out | joy2_out | joy1_press | joy2_press, 16'h0);
      chk(name, {15'h0, menu_pulse | sample_tick}, 16'h0);
      chk(name, b_joy1_out | b_joy2_out | b_joy1_press | b_joy2_press, 16'h0);
   endtask

   typedef struct {
      logic [15:0] in1;
      logic [15:0] in2;
      logic [15:0] exp1;
      logic [15:0] exp2;
   } vec_t;

   vec_t vecs [6];
   int   base;

   initial begin
      vecs[0] = '{16'h0010, 16'h0000, 16'h0010, 16'h0000};
      vecs[1] = '{16'h0003, 16'h000C, 16'h0000, 16'h0000};
      vecs[2] = '{16'h000F, 16'h0005, 16'h0000, 16'h0005};
      vecs[3] = '{16'h03F5, 16'h000A, 16'h03F5, 16'h000A};
      vecs[4] = '{16'hF0F1, 16'hFFFF, 16'h00F1, 16'h0FF0};
      vecs[5] = '{16'h0402, 16'h0809, 16'h0402, 16'h0809};

      // Reset held with all buttons asserted.
      wait_clk(2);
      chk_en = 1'b1;
      wait_clk(3);
      chk_all_zero("reset_hold");
      joystick1_in = 16'h0;
      joystick2_in = 16'h0;
      reset_n = 1'b1;
      // Tick is high in the clk period ending at every 4th rising edge.
      for (int k = 1; k <= 12; k++) begin
         wait_clk(1);
         chk("tick_phase", {15'h0, sample_tick}, {15'h0, (k % 4) == 3});
         chk("post_reset_out", joy1_out | joy2_out | joy1_press | joy2_press, 16'h0);
      end

      // Glitch: level seen by only two ticks.
      wait_tick(1);
      base = out4_cnt;
      joystick1_in = 16'h0010;
      wait_tick(2);
      joystick1_in = 16'h0;
      wait_tick(5);
      chk("glitch_out4", 16'(out4_cnt - base), 16'h0);
      chk("glitch_out", joy1_out, 16'h0);

      // Press timing and single pulse.
      joystick1_in = 16'h0010;
      wait_tick(3);
      wait_clk(1);
      chk("press_not_yet", joy1_out, 16'h0);
      wait_clk(1);
      chk("press_out", joy1_out, 16'h0010);
      chk("press_pulse", joy1_press, 16'h0010);
      wait_clk(1);
      chk("press_pulse_end", joy1_press, 16'h0);
      chk("press_out_held", joy1_out, 16'h0010);
      wait_tick(2);
      base = press1_cnt;
      joystick1_in = 16'h0;
      wait_tick(3);
      wait_clk(2);
      chk("release_out", joy1_out, 16'h0);
      wait_tick(2);
      chk("release_no_press", 16'(press1_cnt - base), 16'h0);

      // SOCD neutral vs pass-through, then unmask raises a press.
      joystick2_in = 16'h0003;
      wait_tick(5);
      chk("socd_neutral", joy2_out, 16'h0);
      chk("socd_pass", b_joy2_out, 16'h0003);
      base = p2b0_cnt;
      joystick2_in = 16'h0001;
      wait_tick(5);
      chk("socd_unmask_out", joy2_out, 16'h0001);
      chk("socd_unmask_press", 16'(p2b0_cnt - base), 16'h1);
      chk("socd_pass_drop", b_joy2_out, 16'h0001);
      joystick2_in = 16'h0;
      wait_tick(5);

      // Combo: one pulse per hold, none while held longer.
      for (int r = 0; r < 2; r++) begin
         base = menu_cnt;
         joystick1_in = 16'h0C00;
         wait_tick(3 + CT + 20);
         chk("combo_single", 16'(menu_cnt - base), 16'h1);
         chk("combo_buttons_visible", joy1_out, 16'h0C00);
         joystick1_in = 16'h0;
         wait_tick(6);
      end

      // Combo released so it drops just ahead of the final tick: no pulse.
      wait_tick(1);
      base = menu_cnt;
      joystick1_in = 16'h0C00;
      wait_tick(4);
      joystick1_in = 16'h0;
      wait_tick(8);
      chk("combo_early_release", 16'(menu_cnt - base), 16'h0);

      // Vector table of settled conditioned levels.
      foreach (vecs[i]) begin
         joystick1_in = vecs[i].in1;
         joystick2_in = vecs[i].in2;
         wait_tick(5);
         chk($sformatf("vec%0d_joy1", i), joy1_out, vecs[i].exp1);
         chk($sformatf("vec%0d_joy2", i), joy2_out, vecs[i].exp2);
      end
      joystick1_in = 16'h0;
      joystick2_in = 16'h0;
      wait_tick(8);

      // Asynchronous reset while in HOLD.
      joystick2_in = 16'h0C00;
      wait_tick(6);
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk_all_zero("async_reset");
      wait_clk(3);
      reset_n = 1'b1;
      base = menu_cnt;
      wait_tick(3);
      chk("debounce_restart", joy2_out, 16'h0);
      chk("no_stale_menu", 16'(menu_cnt - base), 16'h0);
      wait_tick(15);
      chk("menu_after_reset", 16'(menu_cnt - base), 16'h1);
      joystick1_in = 16'hF000;
      joystick2_in = 16'hF000;
      wait_tick(6);
      chk("upper_bits_ignored", joy1_out | joy2_out | joy1_press | joy2_press, 16'h0);

      // Randomised traffic against the model, with occasional resets.
      for (int s = 0; s < 250; s++) begin
         if ($urandom_range(0, 3) == 0) begin
            joystick1_in = 16'h0C00 | 16'($urandom_range(0, 16'hFFFF));
         end else begin
            joystick1_in = 16'($urandom_range(0, 16'hFFFF));
         end
         joystick2_in = 16'($urandom_range(0, 16'hFFFF));
         if ($urandom_range(0, 1) == 0) joystick2_in = joystick2_in & 16'hF3FF;
         wait_clk($urandom_range(1, 60));
         if ($urandom_range(0, 40) == 0) begin
            #($urandom_range(1, 3));
            reset_n = 1'b0;
            wait_clk(2);
            reset_n = 1'b1;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
